decode_stage: RTL
=================

# decode_stage

Parametrised, pipelined RV64IM instruction decode stage between the fetch register and execute. It accepts one instruction per cycle over a valid/ready handshake and reads two operands from the external register file, with writeback bypass and x0 forcing. It produces a registered decode bundle: class, funct, sign-extended immediate and operands. It also adds what the previous decoder lacked: backpressure, a load-use interlock, flush, illegal-instruction flagging and a saturating stall counter.

## Interface
- `XLEN`, 64: datapath and PC width.
- `NREG`, 32: architectural register count; index width `RW = $clog2(NREG)`.
- `STALL_CNT_W`, 16: width of the stall counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch bundle valid.
- `in_ready`  out  1  decode can accept this cycle.
- `in_instr`  in  32  instruction word.
- `in_npc`  in  XLEN  next PC of the instruction.
- `rf_raddr1`, `rf_raddr2`  out  RW  combinational register-file read addresses, driven from `in_instr[19:15]` and `in_instr[24:20]`.
- `rf_rdata1`, `rf_rdata2`  in  XLEN  same-cycle read data.
- `wb_en`  in  1  writeback this cycle.
- `wb_rd`  in  RW  writeback destination.
- `wb_data`  in  XLEN  writeback value.
- `ex_load_valid`  in  1  execute holds a load.
- `ex_load_rd`  in  RW  destination of that load.
- `flush`  in  1  kill the held and incoming instruction.
- `out_valid`  out  1  decode bundle valid.
- `out_ready`  in  1  execute accepts.
- `out_class`  out  4  0 ILLEGAL, 1 ALU_R, 2 ALU_I, 3 LOAD, 4 STORE, 5 BRANCH, 6 LUI, 7 AUIPC, 8 JAL, 9 JALR, 10 SYSTEM, 11 MULDIV.
- `out_funct3`  out  3  `instr[14:12]`.
- `out_alt`  out  1  `instr[30]` (sub/sra); 0 for non-ALU classes.
- `out_word`  out  1  set for the OP-32 and OP-IMM-32 opcodes.
- `out_rd`  out  RW  destination; 0 for STORE, BRANCH and ILLEGAL.
- `out_rs1_val`, `out_rs2_val`  out  XLEN  operand values.
- `out_imm`  out  XLEN  immediate.
- `out_npc`  out  XLEN  forwarded `in_npc`.
- `out_illegal`  out  1  equals `out_class==0`.
- `stall_cnt`  out  STALL_CNT_W  hazard-stall cycle count.

## Operation
- **Class by `instr[6:0]`:**
  - 0110011: ALU_R, or MULDIV when `instr[25]`=1.
  - 0111011: ALU_R or MULDIV by the same `instr[25]` rule, with word=1.
  - 0010011: ALU_I.
  - 0011011: ALU_I with word=1.
  - 0000011: LOAD; `funct3`=111 is illegal.
  - 0100011: STORE; `funct3`>011 is illegal.
  - 1100011: BRANCH; `funct3` 010 and 011 are illegal.
  - 0110111: LUI.
  - 0010111: AUIPC.
  - 1101111: JAL.
  - 1100111: JALR.
  - 1110011: SYSTEM.
  - Any other opcode is ILLEGAL.
- **Immediates**, all sign-extended from `instr[31]` to XLEN:
  - I: `instr[31:20]`.
  - S: `{[31:25],[11:7]}`.
  - B: `{[31],[7],[30:25],[11:8],0}`.
  - U: `{[31:12],12'b0}`.
  - J: `{[31],[19:12],[20],[30:21],0}`.
  - ALU_I shifts (`funct3` 001/101): zero-extended shamt, `instr[25:20]` (or `[24:20]` when word=1).
  - R, MULDIV and ILLEGAL: 0.
- **Operand source priority:**
  1. Register index 0 gives 0.
  2. Otherwise, `wb_en && wb_rd==idx` gives `wb_data`.
  3. Otherwise, `rf_rdata`.
  - An unused operand (rs1 for LUI/AUIPC/JAL; rs2 for anything other than ALU_R/MULDIV/STORE/BRANCH) is forced to 0.
- **Load-use hazard:** `in_valid && ex_load_valid && ex_load_rd!=0` and a *used* rs index equals `ex_load_rd`.
- **Handshake:** `in_ready = (!out_valid || out_ready) && !hazard`. The instruction is captured when `in_valid && in_ready && !flush`.
- **Output register:**
  - Next `out_valid` is 0 on flush.
  - Otherwise it is 1 on capture.
  - Otherwise it is 0 when `out_ready` is high.
  - Otherwise it holds.
  - Held bundle bits are stable while `out_valid && !out_ready`.
- **Stall counter:** increments on every cycle with `hazard` high. It saturates at all-ones and is not cleared by flush.

## Timing
- **Reset:** asynchronous assertion clears every registered output to 0: `out_valid`, all bundle fields and `stall_cnt`. `in_ready` is 1 after reset when there is no hazard. Deassertion is synchronous to `clk`.
- **Latency:** 1 cycle from capture to `out_valid`. Throughput is 1 instruction per cycle when `out_ready` is held high.
- **Combinational paths:** the `in_ready` path depends on `out_ready`, `in_*` and `ex_load_*`. It must not depend on `flush`.
- **Flush:** flush and capture in the same cycle results in no capture and `out_valid`=0 next cycle. Flush while stalled drops the held bundle.
- **Bypass:** `wb` in the same cycle as capture is bypassed. A writeback after capture does not update a held bundle; execute forwarding covers that case.
- **Simultaneous events:** hazard and `out_ready` low together: in_ready=0, and the counter increments.
- **Reset mid-stall:** the bundle is lost and `out_valid`=0 immediately.

## Test plan
- **Reset then add:** after reset, `add x3,x1,x2` with rf x1=5, x2=7 → next cycle `out_valid`=1, class=1, `out_rd`=3, rs1_val=5, rs2_val=7, imm=0.
- **Immediates:** `addi x1,x0,-1` → imm=0xFFFF_FFFF_FFFF_FFFF, rs1_val=0. `beq` with offset -4 → imm=-4. `lui x5,0x80000` → imm=0xFFFF_FFFF_8000_0000.
- **Bypass and x0:** wb_en=1, wb_rd=1, wb_data=99 with `sub x4,x1,x0`, rf x1=5 → rs1_val=99, rs2_val=0, alt=1.
- **Load-use interlock:** ex_load_valid=1, ex_load_rd=2, `sd x2,0(x3)` → in_ready=0 for 3 held cycles and stall_cnt=3. `lui x2` under the same hazard is not stalled.
- **Backpressure and flush:** out_ready=0 for 4 cycles → bundle stable and in_ready=0. Flush asserted with in_valid=1 → out_valid=0 next cycle and no capture.
- **Illegal:** opcode 0x7F and `ld` with funct3=111 → class=0, out_illegal=1, rd=0.

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage : RV64IM decode with handshake, bypass, load-use interlock, flush
// Revision     : 1.0
// ============================================================================
module decode_stage #(
  parameter int XLEN        = 64,
  parameter int NREG        = 32,
  parameter int STALL_CNT_W = 16,
  localparam int RW         = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_npc,
  output logic [RW-1:0]          rf_raddr1,
  output logic [RW-1:0]          rf_raddr2,
  input  logic [XLEN-1:0]        rf_rdata1,
  input  logic [XLEN-1:0]        rf_rdata2,
  input  logic                   wb_en,
  input  logic [RW-1:0]          wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   ex_load_valid,
  input  logic [RW-1:0]          ex_load_rd,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_class,
  output logic [2:0]             out_funct3,
  output logic                   out_alt,
  output logic                   out_word,
  output logic [RW-1:0]          out_rd,
  output logic [XLEN-1:0]        out_rs1_val,
  output logic [XLEN-1:0]        out_rs2_val,
  output logic [XLEN-1:0]        out_imm,
  output logic [XLEN-1:0]        out_npc,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] c_cls_illegal = 4'd0;
  localparam logic [3:0] c_cls_alu_r   = 4'd1;
  localparam logic [3:0] c_cls_alu_i   = 4'd2;
  localparam logic [3:0] c_cls_load    = 4'd3;
  localparam logic [3:0] c_cls_store   = 4'd4;
  localparam logic [3:0] c_cls_branch  = 4'd5;
  localparam logic [3:0] c_cls_lui     = 4'd6;
  localparam logic [3:0] c_cls_auipc   = 4'd7;
  localparam logic [3:0] c_cls_jal     = 4'd8;
  localparam logic [3:0] c_cls_jalr    = 4'd9;
  localparam logic [3:0] c_cls_system  = 4'd10;
  localparam logic [3:0] c_cls_muldiv  = 4'd11;

  localparam logic [6:0] c_op_op       = 7'b0110011;
  localparam logic [6:0] c_op_op32     = 7'b0111011;
  localparam logic [6:0] c_op_imm      = 7'b0010011;
  localparam logic [6:0] c_op_imm32    = 7'b0011011;
  localparam logic [6:0] c_op_load     = 7'b0000011;
  localparam logic [6:0] c_op_store    = 7'b0100011;
  localparam logic [6:0] c_op_branch   = 7'b1100011;
  localparam logic [6:0] c_op_lui      = 7'b0110111;
  localparam logic [6:0] c_op_auipc    = 7'b0010111;
  localparam logic [6:0] c_op_jal      = 7'b1101111;
  localparam logic [6:0] c_op_jalr     = 7'b1100111;
  localparam logic [6:0] c_op_system   = 7'b1110011;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic [3:0]      w_cls;
  logic            w_word;
  logic            w_alt;
  logic [RW-1:0]   w_rd;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_hazard;
  logic            w_capture;

  logic                   out_valid_q, out_valid_d;
  logic [3:0]             class_q;
  logic [2:0]             funct3_q;
  logic                   alt_q;
  logic                   word_q;
  logic [RW-1:0]          rd_q;
  logic [XLEN-1:0]        rs1_val_q;
  logic [XLEN-1:0]        rs2_val_q;
  logic [XLEN-1:0]        imm_q;
  logic [XLEN-1:0]        npc_q;
  logic                   illegal_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign w_opcode  = in_instr[6:0];
  assign w_funct3  = in_instr[14:12];
  assign w_rs1     = RW'(in_instr[19:15]);
  assign w_rs2     = RW'(in_instr[24:20]);
  assign rf_raddr1 = w_rs1;
  assign rf_raddr2 = w_rs2;

  always_comb begin
    w_cls  = c_cls_illegal;
    w_word = 1'b0;
    case (w_opcode)
      c_op_op:     w_cls = in_instr[25] ? c_cls_muldiv : c_cls_alu_r;
      c_op_op32: begin
        w_cls  = in_instr[25] ? c_cls_muldiv : c_cls_alu_r;
        w_word = 1'b1;
      end
      c_op_imm:    w_cls = c_cls_alu_i;
      c_op_imm32: begin
        w_cls  = c_cls_alu_i;
        w_word = 1'b1;
      end
      c_op_load:   w_cls = (w_funct3 == 3'b111) ? c_cls_illegal : c_cls_load;
      c_op_store:  w_cls = (w_funct3 > 3'b011) ? c_cls_illegal : c_cls_store;
      c_op_branch: w_cls = (w_funct3[2:1] == 2'b01) ? c_cls_illegal : c_cls_branch;
      c_op_lui:    w_cls = c_cls_lui;
      c_op_auipc:  w_cls = c_cls_auipc;
      c_op_jal:    w_cls = c_cls_jal;
      c_op_jalr:   w_cls = c_cls_jalr;
      c_op_system: w_cls = c_cls_system;
      default:     w_cls = c_cls_illegal;
    endcase
  end

  assign w_alt = ((w_cls == c_cls_alu_r) || (w_cls == c_cls_alu_i)) ? in_instr[30] : 1'b0;
  assign w_rd  = ((w_cls == c_cls_store) || (w_cls == c_cls_branch) || (w_cls == c_cls_illegal))
               ? '0 : RW'(in_instr[11:7]);

  assign w_imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
  assign w_shamt = w_word ? {{(XLEN-5){1'b0}}, in_instr[24:20]}
                          : {{(XLEN-6){1'b0}}, in_instr[25:20]};

  always_comb begin
    w_imm = '0;
    case (w_cls)
      c_cls_alu_i:  w_imm = (w_funct3[1:0] == 2'b01) ? w_shamt : w_imm_i;
      c_cls_load,
      c_cls_jalr,
      c_cls_system: w_imm = w_imm_i;
      c_cls_store:  w_imm = w_imm_s;
      c_cls_branch: w_imm = w_imm_b;
      c_cls_lui,
      c_cls_auipc:  w_imm = w_imm_u;
      c_cls_jal:    w_imm = w_imm_j;
      default:      w_imm = '0;
    endcase
  end

  assign w_use_rs1 = !((w_cls == c_cls_lui) || (w_cls == c_cls_auipc) || (w_cls == c_cls_jal));
  assign w_use_rs2 = (w_cls == c_cls_alu_r) || (w_cls == c_cls_muldiv) ||
                     (w_cls == c_cls_store) || (w_cls == c_cls_branch);

  // x0 beats bypass, bypass beats the register file, unused operands read as zero
  assign w_rs1_val = (!w_use_rs1 || (w_rs1 == '0)) ? '0 :
                     (wb_en && (wb_rd == w_rs1))   ? wb_data : rf_rdata1;
  assign w_rs2_val = (!w_use_rs2 || (w_rs2 == '0)) ? '0 :
                     (wb_en && (wb_rd == w_rs2))   ? wb_data : rf_rdata2;

  assign w_hazard = in_valid && ex_load_valid && (ex_load_rd != '0) &&
                    ((w_use_rs1 && (w_rs1 == ex_load_rd)) || (w_use_rs2 && (w_rs2 == ex_load_rd)));

  assign in_ready  = (!out_valid_q || out_ready) && !w_hazard;
  assign w_capture = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (w_capture) out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  assign stall_cnt_d = (w_hazard && (stall_cnt_q != '1)) ? stall_cnt_q + STALL_CNT_W'(1)
                                                        : stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      class_q     <= '0;
      funct3_q    <= '0;
      alt_q       <= 1'b0;
      word_q      <= 1'b0;
      rd_q        <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      imm_q       <= '0;
      npc_q       <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (w_capture) begin
        class_q   <= w_cls;
        funct3_q  <= w_funct3;
        alt_q     <= w_alt;
        word_q    <= w_word;
        rd_q      <= w_rd;
        rs1_val_q <= w_rs1_val;
        rs2_val_q <= w_rs2_val;
        imm_q     <= w_imm;
        npc_q     <= in_npc;
        illegal_q <= (w_cls == c_cls_illegal);
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_class   = class_q;
  assign out_funct3  = funct3_q;
  assign out_alt     = alt_q;
  assign out_word    = word_q;
  assign out_rd      = rd_q;
  assign out_rs1_val = rs1_val_q;
  assign out_rs2_val = rs2_val_q;
  assign out_imm     = imm_q;
  assign out_npc     = npc_q;
  assign out_illegal = illegal_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire
